// File: rtl/wb_multibot_regs.sv
// Wishbone register block serving NUM_BOTS rojobot channels: per-channel control,
// update snapshot, pending/overrun tracking with W1C acknowledge, counters and interrupt.
module wb_multibot_regs #(
   parameter int NUM_BOTS = 2,
   parameter int CTRL_W   = 8,
   parameter int INFO_W   = 32,
   parameter int CNT_W    = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [31:0]                  wb_adr_i,
   input  logic [31:0]                  wb_dat_i,
   input  logic [3:0]                   wb_sel_i,
   input  logic                         wb_we_i,
   input  logic                         wb_cyc_i,
   input  logic                         wb_stb_i,
   output logic [31:0]                  wb_dat_o,
   output logic                         wb_ack_o,
   output logic                         wb_err_o,
   output logic                         wb_rtry_o,
   output logic [NUM_BOTS*CTRL_W-1:0]   bot_ctrl,
   input  logic [NUM_BOTS*INFO_W-1:0]   bot_info,
   input  logic [NUM_BOTS-1:0]          bot_upd,
   output logic                         irq_o
);

   localparam logic [31:0] ID_VAL = {8'hB0, 8'(NUM_BOTS), 16'h0002};

   logic                  req;
   logic [2:0]            ch;
   logic [2:0]            word;
   logic [31:0]           lane_mask;
   logic [7:0][31:0]      rd_mux;
   logic [NUM_BOTS-1:0]   pending_all;
   logic [NUM_BOTS-1:0]   en_all;
   logic [NUM_BOTS-1:0]   upd_q;
   logic [NUM_BOTS-1:0]   rise;
   logic                  ack;
   logic [31:0]           dat;
   logic                  unused;

   assign req       = wb_cyc_i & wb_stb_i & ~ack;
   assign ch        = wb_adr_i[7:5];
   assign word      = wb_adr_i[4:2];
   assign lane_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
   assign rise      = bot_upd & ~upd_q;

   assign wb_ack_o  = ack;
   assign wb_dat_o  = dat;
   assign wb_err_o  = 1'b0;
   assign wb_rtry_o = 1'b0;
   assign irq_o     = |(pending_all & en_all);
   assign unused    = ^{wb_adr_i, wb_dat_i, wb_sel_i, lane_mask};

   for (genvar g = 0; g < NUM_BOTS; g++) begin : g_bot
      logic              hit;
      logic              wr;
      logic              ctrl_wr;
      logic              en_wr;
      logic              clr_pend;
      logic              clr_ovr;
      logic [CTRL_W-1:0] ctrl;
      logic [INFO_W-1:0] info;
      logic [CNT_W-1:0]  cnt;
      logic              pending;
      logic              overrun;
      logic              irq_en;

      assign hit      = req & (ch == 3'(g));
      assign wr       = hit & wb_we_i;
      assign ctrl_wr  = wr & (word == 3'd1);
      assign en_wr    = wr & (word == 3'd4) & wb_sel_i[0];
      assign clr_pend = wr & (word == 3'd3) & wb_sel_i[0] & wb_dat_i[0];
      assign clr_ovr  = wr & (word == 3'd3) & wb_sel_i[0] & wb_dat_i[1];

      always_ff @(posedge clk) begin
         if (reset) begin
            ctrl    <= '0;
            info    <= '0;
            cnt     <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
            irq_en  <= 1'b0;
         end else begin
            if (ctrl_wr)
               ctrl <= (ctrl & ~lane_mask[CTRL_W-1:0]) | (wb_dat_i[CTRL_W-1:0] & lane_mask[CTRL_W-1:0]);
            if (en_wr)
               irq_en <= wb_dat_i[0];
            if (rise[g]) begin
               info <= bot_info[g*INFO_W +: INFO_W];
               cnt  <= cnt + CNT_W'(1);
            end
            // a new edge beats a same-cycle acknowledge; an overrun clear beats a new overrun
            pending <= rise[g] | (pending & ~clr_pend);
            overrun <= ~clr_ovr & (overrun | (rise[g] & pending & ~clr_pend));
         end
      end

      assign bot_ctrl[g*CTRL_W +: CTRL_W] = ctrl;
      assign pending_all[g] = pending;
      assign en_all[g]      = irq_en;

      assign rd_mux[g] = (word == 3'd0) ? 32'(info) :
                         (word == 3'd1) ? 32'(ctrl) :
                         (word == 3'd2) ? {16'(cnt), 14'd0, overrun, pending} :
                         (word == 3'd4) ? {31'd0, irq_en} : '0;
   end

   for (genvar g = NUM_BOTS; g < 7; g++) begin : g_pad
      assign rd_mux[g] = '0;
   end

   // slot 7 (0xE0..0xFF) never aliases a channel because NUM_BOTS is at most 7
   assign rd_mux[7] = (word == 3'd0) ? 32'(pending_all & en_all) :
                      (word == 3'd1) ? ID_VAL : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         ack   <= 1'b0;
         dat   <= '0;
         upd_q <= '0;
      end else begin
         upd_q <= bot_upd;
         ack   <= req;
         if (req)
            dat <= wb_we_i ? '0 : rd_mux[ch];
      end
   end

endmodule

// File: tb/tb_wb_multibot_regs.sv
// Directed bench for wb_multibot_regs: bus access, channel updates, ack races, wrap and reset.
module tb_wb_multibot_regs;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o, wb_rtry_o;
   logic [15:0] bot_ctrl;
   logic [63:0] bot_info;
   logic [1:0]  bot_upd;
   logic        irq_o;

   int tests = 0;
   int fails = 0;
   logic [31:0] rd;

   always #5 clk = ~clk;

   wb_multibot_regs #(.NUM_BOTS(2), .CTRL_W(8), .INFO_W(32), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
      .wb_err_o(wb_err_o), .wb_rtry_o(wb_rtry_o),
      .bot_ctrl(bot_ctrl), .bot_info(bot_info), .bot_upd(bot_upd), .irq_o(irq_o)
   );

   task automatic bus_xfer(input logic [31:0] adr, input logic we, input logic [31:0] d,
                           input logic [3:0] sel, output logic [31:0] q);
      logic got;
      got = 1'b0;
      q   = '0;
      @(posedge clk); #1;
      wb_adr_i = adr; wb_we_i = we; wb_dat_i = d; wb_sel_i = sel;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (wb_ack_o) begin
            q = wb_dat_o;
            got = 1'b1;
            break;
         end
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      if (!got) begin
         tests++; fails++;
         $display("FAIL bus_timeout adr=%h: no ack, required ack within 8 cycles", adr);
      end
   endtask

   task automatic bus_wr(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel);
      logic [31:0] dummy;
      bus_xfer(adr, 1'b1, d, sel, dummy);
   endtask

   task automatic bus_rd(input logic [31:0] adr, output logic [31:0] q);
      bus_xfer(adr, 1'b0, '0, 4'hF, q);
   endtask

   task automatic pulse_upd(input int chn, input logic [31:0] info);
      @(posedge clk); #1;
      bot_info[chn*32 +: 32] = info;
      bot_upd[chn] = 1'b1;
      @(posedge clk); #1;
      bot_upd[chn] = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      tests++; if (bot_ctrl !== 16'h0) begin fails++; $display("FAIL rst_ctrl: got %h, expected 0000", bot_ctrl); end
      tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL rst_irq: got %b, expected 0", irq_o); end
      tests++; if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin fails++; $display("FAIL rst_bus: ack=%b dat=%h, expected 0/0", wb_ack_o, wb_dat_o); end
      // ID read with explicit single-cycle ack timing
      @(posedge clk); #1;
      wb_adr_i = 32'hE4; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      @(posedge clk); #1;
      tests++; if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'hB002_0002) begin fails++; $display("FAIL id_read: ack=%b dat=%h, expected 1/b0020002", wb_ack_o, wb_dat_o); end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      @(posedge clk); #1;
      tests++; if (wb_ack_o !== 1'b0) begin fails++; $display("FAIL ack_pulse: got %b, expected 0", wb_ack_o); end
   endtask

   task automatic test_ctrl;
      bus_wr(32'h24, 32'h0000_00A5, 4'b0001);
      tests++; if (bot_ctrl !== 16'hA500) begin fails++; $display("FAIL ctrl_wr: got %h, expected a500", bot_ctrl); end
      bus_wr(32'h24, 32'h0000_5A00, 4'b0010);
      tests++; if (bot_ctrl !== 16'hA500) begin fails++; $display("FAIL ctrl_lane1: got %h, expected a500", bot_ctrl); end
      bus_rd(32'h24, rd);
      tests++; if (rd !== 32'h0000_00A5) begin fails++; $display("FAIL ctrl_rd: got %h, expected 000000a5", rd); end
      bus_wr(32'h04, 32'h0000_00FF, 4'b0000);
      tests++; if (bot_ctrl !== 16'hA500) begin fails++; $display("FAIL ctrl_nosel: got %h, expected a500", bot_ctrl); end
      bus_wr(32'h04, 32'hFFFF_FF3C, 4'b1111);
      tests++; if (bot_ctrl !== 16'hA53C) begin fails++; $display("FAIL ctrl_ch0: got %h, expected a53c", bot_ctrl); end
   endtask

   task automatic test_update;
      pulse_upd(0, 32'h1234_5678);
      bus_rd(32'h08, rd);
      tests++; if (rd !== 32'h0001_0001) begin fails++; $display("FAIL upd_status: got %h, expected 00010001", rd); end
      bus_rd(32'h00, rd);
      tests++; if (rd !== 32'h1234_5678) begin fails++; $display("FAIL upd_info: got %h, expected 12345678", rd); end
      tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL irq_disabled: got %b, expected 0", irq_o); end
      bus_wr(32'h10, 32'h1, 4'b0001);
      tests++; if (irq_o !== 1'b1) begin fails++; $display("FAIL irq_enable: got %b, expected 1", irq_o); end
      bus_rd(32'hE0, rd);
      tests++; if (rd !== 32'h1) begin fails++; $display("FAIL irq_sum: got %h, expected 00000001", rd); end
      bus_wr(32'h0C, 32'h1, 4'b0001);
      tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL irq_ack: got %b, expected 0", irq_o); end
      bus_rd(32'h08, rd);
      tests++; if (rd !== 32'h0001_0000) begin fails++; $display("FAIL ack_status: got %h, expected 00010000", rd); end
      bus_rd(32'h0C, rd);
      tests++; if (rd !== 32'h0) begin fails++; $display("FAIL ack_rd: got %h, expected 0", rd); end
      bus_rd(32'h10, rd);
      tests++; if (rd !== 32'h1) begin fails++; $display("FAIL en_rd: got %h, expected 1", rd); end
   endtask

   task automatic test_overrun;
      pulse_upd(1, 32'h1111_1111);
      pulse_upd(1, 32'h2222_2222);
      bus_rd(32'h28, rd);
      tests++; if (rd !== 32'h0002_0003) begin fails++; $display("FAIL ovr_status: got %h, expected 00020003", rd); end
      bus_rd(32'h20, rd);
      tests++; if (rd !== 32'h2222_2222) begin fails++; $display("FAIL ovr_info: got %h, expected 22222222", rd); end
      bus_wr(32'h2C, 32'h2, 4'b0001);
      bus_rd(32'h28, rd);
      tests++; if (rd !== 32'h0002_0001) begin fails++; $display("FAIL ovr_clear: got %h, expected 00020001", rd); end
      tests++; if (irq_o !== 1'b0) begin fails++; $display("FAIL irq_ch1_off: got %b, expected 0", irq_o); end
      bus_wr(32'h30, 32'h1, 4'b0001);
      bus_rd(32'hE0, rd);
      tests++; if (rd !== 32'h2 || irq_o !== 1'b1) begin fails++; $display("FAIL irq_sum_ch1: got %h irq=%b, expected 00000002 irq=1", rd, irq_o); end
      bus_wr(32'h2C, 32'h1, 4'b0000);
      bus_rd(32'h28, rd);
      tests++; if (rd !== 32'h0002_0001) begin fails++; $display("FAIL ack_nosel: got %h, expected 00020001", rd); end
      bus_wr(32'h2C, 32'h1, 4'b0001);
      bus_rd(32'h28, rd);
      tests++; if (rd !== 32'h0002_0000 || irq_o !== 1'b0) begin fails++; $display("FAIL ch1_clear: got %h irq=%b, expected 00020000 irq=0", rd, irq_o); end
   endtask

   task automatic race_xfer(input logic [31:0] adr, input logic we, input logic [31:0] d,
                            input logic [31:0] info, output logic [31:0] q);
      @(posedge clk); #1;
      wb_adr_i = adr; wb_we_i = we; wb_dat_i = d; wb_sel_i = 4'hF;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      bot_info[31:0] = info; bot_upd[0] = 1'b1;
      @(posedge clk); #1;
      q = wb_dat_o;
      tests++; if (wb_ack_o !== 1'b1) begin fails++; $display("FAIL race_ack adr=%h: got %b, expected 1", adr, wb_ack_o); end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; bot_upd[0] = 1'b0;
   endtask

   task automatic test_back_to_back;
      pulse_upd(0, 32'hAAAA_0001);
      race_xfer(32'h0C, 1'b1, 32'h1, 32'hCAFE_F00D, rd);
      bus_rd(32'h08, rd);
      tests++; if (rd !== 32'h0003_0001) begin fails++; $display("FAIL race_ackpend: got %h, expected 00030001", rd); end
      tests++; if (irq_o !== 1'b1) begin fails++; $display("FAIL race_irq: got %b, expected 1", irq_o); end
      race_xfer(32'h00, 1'b0, 32'h0, 32'h0BAD_BEEF, rd);
      tests++; if (rd !== 32'hCAFE_F00D) begin fails++; $display("FAIL race_info_old: got %h, expected cafef00d", rd); end
      bus_rd(32'h08, rd);
      tests++; if (rd !== 32'h0004_0003) begin fails++; $display("FAIL race_ovr: got %h, expected 00040003", rd); end
      bus_rd(32'h00, rd);
      tests++; if (rd !== 32'h0BAD_BEEF) begin fails++; $display("FAIL race_info_new: got %h, expected 0badbeef", rd); end
      race_xfer(32'h0C, 1'b1, 32'h2, 32'h0000_0055, rd);
      bus_rd(32'h08, rd);
      tests++; if (rd !== 32'h0005_0001) begin fails++; $display("FAIL race_ovrclr: got %h, expected 00050001", rd); end
      bus_wr(32'h0C, 32'h3, 4'b0001);
      bus_rd(32'h08, rd);
      tests++; if (rd !== 32'h0005_0000) begin fails++; $display("FAIL clr_both: got %h, expected 00050000", rd); end
   endtask

   task automatic test_hold_wrap;
      @(posedge clk); #1;
      bot_info[31:0] = 32'h0000_0066; bot_upd[0] = 1'b1;
      repeat (10) @(posedge clk);
      #1 bot_upd[0] = 1'b0;
      bus_rd(32'h08, rd);
      tests++; if (rd !== 32'h0006_0001) begin fails++; $display("FAIL hold_once: got %h, expected 00060001", rd); end
      bus_rd(32'h00, rd);
      tests++; if (rd !== 32'h0000_0066) begin fails++; $display("FAIL hold_info: got %h, expected 00000066", rd); end
      // channel 1 count is 2; 254 more edges wrap an 8-bit counter to 0
      for (int i = 0; i < 254; i++) pulse_upd(1, 32'h0000_0100 + 32'(i));
      bus_rd(32'h28, rd);
      tests++; if (rd !== 32'h0000_0003) begin fails++; $display("FAIL cnt_wrap: got %h, expected 00000003", rd); end
      bus_rd(32'h20, rd);
      tests++; if (rd !== 32'h0000_01FD) begin fails++; $display("FAIL wrap_info: got %h, expected 000001fd", rd); end
   endtask

   task automatic test_out_of_range;
      bus_rd(32'h60, rd);
      tests++; if (rd !== 32'h0) begin fails++; $display("FAIL oor_ch3: got %h, expected 0", rd); end
      bus_rd(32'h40, rd);
      tests++; if (rd !== 32'h0) begin fails++; $display("FAIL oor_ch2: got %h, expected 0", rd); end
      bus_rd(32'hE8, rd);
      tests++; if (rd !== 32'h0) begin fails++; $display("FAIL unmapped_e8: got %h, expected 0", rd); end
      bus_rd(32'h34, rd);
      tests++; if (rd !== 32'h0) begin fails++; $display("FAIL unmapped_34: got %h, expected 0", rd); end
      bus_wr(32'h64, 32'hFFFF_FFFF, 4'hF);
      bus_wr(32'h44, 32'hFFFF_FFFF, 4'hF);
      tests++; if (bot_ctrl !== 16'hA53C) begin fails++; $display("FAIL oor_write: got %h, expected a53c", bot_ctrl); end
   endtask

   task automatic test_reset_mid;
      @(posedge clk); #1;
      wb_adr_i = 32'h24; wb_we_i = 1'b1; wb_dat_i = 32'h77; wb_sel_i = 4'b0001;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      reset = 1'b1; bot_upd[1] = 1'b1; bot_info[63:32] = 32'h0000_0ABC;
      @(posedge clk); #1;
      tests++; if (wb_ack_o !== 1'b0 || bot_ctrl !== 16'h0 || irq_o !== 1'b0) begin fails++; $display("FAIL rst_mid: ack=%b ctrl=%h irq=%b, expected 0/0000/0", wb_ack_o, bot_ctrl, irq_o); end
      reset = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      @(posedge clk); #1;
      tests++; if (wb_ack_o !== 1'b0) begin fails++; $display("FAIL rst_mid_ack: got %b, expected 0", wb_ack_o); end
      bot_upd[1] = 1'b0;
      bus_rd(32'h24, rd);
      tests++; if (rd !== 32'h0) begin fails++; $display("FAIL rst_mid_ctrl: got %h, expected 0", rd); end
      bus_rd(32'h28, rd);
      tests++; if (rd !== 32'h0001_0001) begin fails++; $display("FAIL rst_first_edge: got %h, expected 00010001", rd); end
      bus_rd(32'h20, rd);
      tests++; if (rd !== 32'h0000_0ABC) begin fails++; $display("FAIL rst_edge_info: got %h, expected 00000abc", rd); end
      bus_rd(32'h08, rd);
      tests++; if (rd !== 32'h0) begin fails++; $display("FAIL rst_ch0_status: got %h, expected 0", rd); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      bot_info = '0; bot_upd = '0;
      test_reset;
      test_ctrl;
      test_update;
      test_overrun;
      test_back_to_back;
      test_hold_wrap;
      test_out_of_range;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
